ustawienie_seq: RTL and testbench

- Sequential controller for the bit-set datapath of the synchronous arithmetic unit.
- Accepts one request: operand A, 1-based start index B and bit count N. Sets N consecutive bits of A, one bit per clock, accumulating into an internal register.
- Returns the result with a valid/ready handshake and flags range errors before any cycle is spent.
- Sits between the arithmetic unit's operation decoder and the result bus.

---
 rtl/ustawienie_seq.sv | 137 +++++++++++++
 tb/tb_ustawienie_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ustawienie_seq.sv
// rtl/ustawienie_seq.sv - sequential bit-set controller: sets N consecutive bits of A from 1-based index B, one per clock
// Optional macro USTAWIENIE_SEQ_ABORT_EN adds i_abort to cut a RUN short with an error result.
module ustawienie_seq #(
  parameter int BITS  = 32,
  parameter int CNT_W = $clog2(BITS + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rsn,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic signed [BITS-1:0] i_arg_A,
  input  logic signed [BITS-1:0] i_arg_B,
  input  logic [CNT_W-1:0]       i_count,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [BITS-1:0]        o_result,
  output logic                   o_error,
  output logic                   o_busy
`ifdef USTAWIENIE_SEQ_ABORT_EN
  ,
  input  logic                   i_abort
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [BITS-1:0]  acc;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] rem;
  logic [BITS-1:0]  result;
  logic             error;

  logic [BITS:0]    end_idx;
  logic             req_err;
  logic [CNT_W-1:0] b_idx;
  logic             abort_now;

  // Index k addresses bit BITS-k, so index 1 is the MSB and index BITS the LSB.
  function automatic logic [BITS-1:0] bit_mask(input logic [CNT_W-1:0] k);
    logic [BITS-1:0] m;
    m = '0;
    if (k != '0 && int'(k) <= BITS)
      m[BITS - int'(k)] = 1'b1;
    return m;
  endfunction

  // End index is computed one bit wider than the operand so a large B+N cannot wrap into range.
  always_comb begin
    end_idx = {1'b0, $unsigned(i_arg_B)}
            + {{(BITS + 1 - CNT_W){1'b0}}, i_count}
            - {{BITS{1'b0}}, 1'b1};
    req_err = i_arg_B[BITS-1]
           || (i_arg_B == '0)
           || ($unsigned(i_arg_B) > BITS'(BITS))
           || (end_idx > (BITS + 1)'(BITS));
    b_idx   = i_arg_B[CNT_W-1:0];
  end

`ifdef USTAWIENIE_SEQ_ABORT_EN
  assign abort_now = i_abort;
`else
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= '0;
      rem    <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (req_err) begin
              acc    <= '0;
              result <= '0;
              error  <= 1'b1;
              state  <= DONE;
            end else if (i_count == '0) begin
              acc    <= i_arg_A;
              result <= i_arg_A;
              error  <= 1'b0;
              state  <= DONE;
            end else if (i_count == CNT_W'(1)) begin
              acc    <= i_arg_A | bit_mask(b_idx);
              result <= i_arg_A | bit_mask(b_idx);
              error  <= 1'b0;
              state  <= DONE;
            end else begin
              // The accept edge already sets the first bit, keeping latency at N edges.
              acc    <= i_arg_A | bit_mask(b_idx);
              idx    <= b_idx + 1'b1;
              rem    <= i_count - 1'b1;
              result <= '0;
              error  <= 1'b0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_now) begin
            acc    <= '0;
            result <= '0;
            error  <= 1'b1;
            state  <= DONE;
          end else begin
            acc <= acc | bit_mask(idx);
            if (rem == CNT_W'(1)) begin
              result <= acc | bit_mask(idx);
              error  <= 1'b0;
              state  <= DONE;
            end else begin
              idx <= idx + 1'b1;
              rem <= rem - 1'b1;
            end
          end
        end
        DONE: begin
          if (i_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_busy   = (state == RUN);
  assign o_valid  = (state == DONE);
  assign o_result = result;
  assign o_error  = error;

endmodule

// File: tb/tb_ustawienie_seq.sv
// tb/tb_ustawienie_seq.sv - directed table-driven bench for ustawienie_seq
module tb_ustawienie_seq;

  logic        clk;
  logic        rsn;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] arg_a;
  logic [31:0] arg_b;
  logic [5:0]  count;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_error;
  logic        o_busy;
`ifdef USTAWIENIE_SEQ_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  ustawienie_seq #(.BITS(32), .CNT_W(6)) dut (
    .i_clk    (clk),
    .i_rsn    (rsn),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_arg_A  (arg_a),
    .i_arg_B  (arg_b),
    .i_count  (count),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_error  (o_error),
    .o_busy   (o_busy)
`ifdef USTAWIENIE_SEQ_ABORT_EN
    ,
    .i_abort  (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  n;
    logic [31:0] res;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    logic busy0;
    @(negedge clk);
    chk("ready_idle", {31'b0, o_ready}, 32'd1);
    i_valid = 1'b1;
    arg_a   = v.a;
    arg_b   = v.b;
    count   = v.n;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat   = 1;
    busy0 = o_busy;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("result", o_result, v.res);
    chk("error", {31'b0, o_error}, {31'b0, v.err});
    chk("busy_after_accept", {31'b0, busy0}, {31'b0, (v.n >= 6'd2 && !v.err)});
    chk("busy_done", {31'b0, o_busy}, 32'd0);
    chk("ready_done", {31'b0, o_ready}, 32'd0);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, o_valid}, 32'd1);
      chk("hold_result", o_result, v.res);
      chk("hold_ready", {31'b0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("valid_cleared", {31'b0, o_valid}, 32'd0);
    chk("ready_back", {31'b0, o_ready}, 32'd1);
    chk("result_kept", o_result, v.res);
  endtask

  initial begin
    rsn     = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    arg_a   = '0;
    arg_b   = '0;
    count   = '0;
`ifdef USTAWIENIE_SEQ_ABORT_EN
    abort   = 1'b0;
`endif

    //          a             b             n      res           err   lat hold
    vecs[0]  = '{32'h0000_0000, 32'd29,       6'd4,  32'h0000_000F, 1'b0, 4,  0};
    vecs[1]  = '{32'h0000_0000, 32'd1,        6'd1,  32'h8000_0000, 1'b0, 1,  0};
    vecs[2]  = '{32'hF0F0_F0F0, 32'd1,        6'd32, 32'hFFFF_FFFF, 1'b0, 32, 0};
    vecs[3]  = '{32'h0000_0055, 32'd0,        6'd1,  32'h0000_0000, 1'b1, 1,  0};
    vecs[4]  = '{32'h0000_0055, 32'hFFFF_FFFF,6'd1,  32'h0000_0000, 1'b1, 1,  0};
    vecs[5]  = '{32'h0000_0055, 32'd33,       6'd0,  32'h0000_0000, 1'b1, 1,  0};
    vecs[6]  = '{32'h0000_0055, 32'd30,       6'd4,  32'h0000_0000, 1'b1, 1,  0};
    vecs[7]  = '{32'h1234_5678, 32'd5,        6'd0,  32'h1234_5678, 1'b0, 1,  10};
    vecs[8]  = '{32'h0000_00F0, 32'd25,       6'd8,  32'h0000_00FF, 1'b0, 8,  2};
    vecs[9]  = '{32'h8000_0000, 32'd32,       6'd1,  32'h8000_0001, 1'b0, 1,  0};
    vecs[10] = '{32'h0000_0005, 32'd29,       6'd5,  32'h0000_0000, 1'b1, 1,  0};

    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_error", {31'b0, o_error}, 32'd0);
    rsn = 1'b1;

    for (int i = 0; i < 11; i++)
      run_vec(vecs[i]);

    // Reset lands on the fifth edge after accept of a 16-bit run.
    @(negedge clk);
    i_valid = 1'b1;
    arg_a   = 32'h0;
    arg_b   = 32'd1;
    count   = 6'd16;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrun_busy", {31'b0, o_busy}, 32'd1);
    end
    rsn = 1'b0;
    @(negedge clk);
    rsn = 1'b1;
    chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    chk("mid_rst_result", o_result, 32'd0);
    chk("mid_rst_error", {31'b0, o_error}, 32'd0);
    chk("mid_rst_busy", {31'b0, o_busy}, 32'd0);
    chk("mid_rst_ready", {31'b0, o_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_stale_valid", {31'b0, o_valid}, 32'd0);
    end
    run_vec('{32'h0, 32'd32, 6'd1, 32'h0000_0001, 1'b0, 1, 0});

`ifdef USTAWIENIE_SEQ_ABORT_EN
    @(negedge clk);
    i_valid = 1'b1;
    arg_a   = 32'h0;
    arg_b   = 32'd1;
    count   = 6'd8;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", {31'b0, o_valid}, 32'd1);
    chk("abort_error", {31'b0, o_error}, 32'd1);
    chk("abort_result", o_result, 32'd0);
    chk("abort_busy", {31'b0, o_busy}, 32'd0);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("abort_release", {31'b0, o_ready}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
